esc_spi_sequencer: RTL

ESC_SPI_SEQUENCER -- requirements
Module: esc_spi_sequencer

---
 rtl/esc_spi_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/esc_spi_sequencer.sv
// esc_spi_sequencer: turns ESC read/write commands into one SPI frame of register
// accesses on an SPI-core slave port, then reports data and error status.
module esc_spi_sequencer #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [12:0] cmd_addr,
    input  logic [2:0]  cmd_len,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        spi_select,
    output logic        read_n,
    output logic        write_n,
    output logic [2:0]  mem_addr,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu,
    input  logic        readyfordata,
    input  logic        dataavailable
);

    localparam int WCW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

    // LEN_ERR only delays the error response of an illegal length by one cycle
    typedef enum logic [3:0] {
        IDLE, SS_ON, WAIT_TRDY, WR_TX, WAIT_RRDY, RD_RX,
        STAT_RD, STAT_CLR, SS_OFF, RESP, LEN_ERR
    } state_t;

    state_t          state, state_next;
    logic [1:0]      phase;
    logic [2:0]      byte_idx;
    logic [WCW-1:0]  wait_cnt;
    logic            lat_write;
    logic [12:0]     lat_addr;
    logic [2:0]      lat_len;
    logic [31:0]     lat_wdata;
    logic            stat_flag;

    logic            in_access, in_wait, acc_active, acc_done;
    logic            accept, len_bad, last_byte, wait_expired, stat_bad;
    logic [1:0]      data_idx;
    logic [7:0]      tx_byte;
    logic            unused_bits;

    assign in_access    = (state == SS_ON) || (state == WR_TX) || (state == RD_RX) ||
                          (state == STAT_RD) || (state == STAT_CLR) || (state == SS_OFF);
    assign in_wait      = (state == WAIT_TRDY) || (state == WAIT_RRDY);
    assign acc_active   = in_access && (phase != 2'd2);
    assign acc_done     = in_access && (phase == 2'd2);
    assign accept       = cmd_valid && cmd_ready;
    assign len_bad      = (cmd_len == 3'd0) || (cmd_len > 3'd4);
    assign last_byte    = byte_idx == (lat_len + 3'd1);
    assign wait_expired = wait_cnt == WAIT_LAST;
    assign data_idx     = byte_idx[1:0] - 2'd2;
    assign stat_bad     = data_to_cpu[3] | data_to_cpu[4];
    assign unused_bits  = |data_to_cpu[15:8];

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    // Frame byte: address high, address low + opcode, then data or read dummies
    always_comb begin
        tx_byte = 8'h00;
        if (byte_idx == 3'd0)
            tx_byte = lat_addr[12:5];
        else if (byte_idx == 3'd1)
            tx_byte = {lat_addr[4:0], lat_write ? 3'b100 : 3'b010};
        else if (lat_write)
            tx_byte = lat_wdata[{data_idx, 3'b000} +: 8];
        else if (last_byte)
            tx_byte = 8'hFF;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        spi_select    = 1'b0;
        read_n        = 1'b1;
        write_n       = 1'b1;
        mem_addr      = 3'd0;
        data_from_cpu = 16'h0000;
        unique case (state)
            IDLE:      if (cmd_valid) state_next = len_bad ? LEN_ERR : SS_ON;
            SS_ON:     if (acc_done) state_next = WAIT_TRDY;
            WAIT_TRDY: if (readyfordata) state_next = WR_TX;
                       else if (wait_expired) state_next = STAT_RD;
            WR_TX:     if (acc_done) state_next = WAIT_RRDY;
            WAIT_RRDY: if (dataavailable) state_next = RD_RX;
                       else if (wait_expired) state_next = STAT_RD;
            RD_RX:     if (acc_done) state_next = last_byte ? STAT_RD : WAIT_TRDY;
            STAT_RD:   if (acc_done) state_next = stat_flag ? STAT_CLR : SS_OFF;
            STAT_CLR:  if (acc_done) state_next = SS_OFF;
            SS_OFF:    if (acc_done) state_next = RESP;
            RESP:      state_next = IDLE;
            LEN_ERR:   state_next = RESP;
            default:   state_next = IDLE;
        endcase
        if (acc_active) begin
            spi_select = 1'b1;
            unique case (state)
                SS_ON:    begin write_n = 1'b0; mem_addr = 3'd3; data_from_cpu = 16'h0400; end
                WR_TX:    begin write_n = 1'b0; mem_addr = 3'd1; data_from_cpu = {8'h00, tx_byte}; end
                RD_RX:    begin read_n  = 1'b0; mem_addr = 3'd0; end
                STAT_RD:  begin read_n  = 1'b0; mem_addr = 3'd2; end
                STAT_CLR: begin write_n = 1'b0; mem_addr = 3'd2; end
                SS_OFF:   begin write_n = 1'b0; mem_addr = 3'd3; end
                default:  spi_select = 1'b0;
            endcase
        end
    end

    // Access phase, byte index, wait counter, latched command and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= 2'd0;
            byte_idx  <= 3'd0;
            wait_cnt  <= '0;
            lat_write <= 1'b0;
            lat_addr  <= 13'd0;
            lat_len   <= 3'd0;
            lat_wdata <= 32'd0;
            stat_flag <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
        end else begin
            phase <= acc_active ? phase + 2'd1 : 2'd0;
            if (in_wait && (state_next == state))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (accept) begin
                lat_write <= cmd_write;
                lat_addr  <= cmd_addr;
                lat_len   <= cmd_len;
                lat_wdata <= cmd_wdata;
                byte_idx  <= 3'd0;
                stat_flag <= 1'b0;
                rsp_rdata <= 32'd0;
                rsp_error <= len_bad;
            end
            if (in_wait && (state_next == STAT_RD))
                rsp_error <= 1'b1;
            if ((state == RD_RX) && acc_done && !last_byte)
                byte_idx <= byte_idx + 3'd1;
            // Read data is taken on the edge that ends the second strobe cycle
            if ((state == RD_RX) && (phase == 2'd1) && !lat_write && (byte_idx >= 3'd2))
                rsp_rdata[{data_idx, 3'b000} +: 8] <= data_to_cpu[7:0];
            if ((state == STAT_RD) && (phase == 2'd1)) begin
                stat_flag <= stat_bad;
                if (stat_bad)
                    rsp_error <= 1'b1;
            end
        end
    end

endmodule
